// File: rtl/wb_stage.sv
// Write-back stage of the 16-bit MIPS pipeline: sole driver of the reg_file write port.
// Optional decode-stage bypass is enabled by defining WB_FORWARD_EN.
module wb_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              stall,
    output logic              timeout_err,
    input  logic [ADDR_W-1:0] fwd_addr_1,
    input  logic [ADDR_W-1:0] fwd_addr_2,
    output logic              fwd_hit_1,
    output logic              fwd_hit_2,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic [DATA_W-1:0] fwd_data_2
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       wait_cnt;
    logic [ADDR_W-1:0] pend_dest;
    logic              pend_wr;
    logic              accept;
    logic              expired;

    assign accept  = in_valid && in_ready;
    assign expired = !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && in_is_load) begin
                    state_nxt = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (mem_ready || expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        stall    = (state == WAIT_MEM);
    end

    // Address/data only move on a real write; suppressed r0 writes leave them untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rf_write_en      <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
            timeout_err      <= 1'b0;
            wait_cnt         <= '0;
            pend_dest        <= '0;
            pend_wr          <= 1'b0;
        end else begin
            rf_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_is_load) begin
                            pend_dest <= in_dest;
                            pend_wr   <= in_reg_write;
                            wait_cnt  <= '0;
                        end else if (in_reg_write && (in_dest != '0)) begin
                            rf_write_en      <= 1'b1;
                            rf_write_address <= in_dest;
                            rf_write_data    <= in_alu_result;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_ready) begin
                        if (pend_wr && (pend_dest != '0)) begin
                            rf_write_en      <= 1'b1;
                            rf_write_address <= pend_dest;
                            rf_write_data    <= mem_rdata;
                        end
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    always_comb begin
        fwd_hit_1  = rf_write_en && (rf_write_address == fwd_addr_1) && (fwd_addr_1 != '0);
        fwd_hit_2  = rf_write_en && (rf_write_address == fwd_addr_2) && (fwd_addr_2 != '0);
        fwd_data_1 = rf_write_data;
        fwd_data_2 = rf_write_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr_1, fwd_addr_2};

    always_comb begin
        fwd_hit_1  = 1'b0;
        fwd_hit_2  = 1'b0;
        fwd_data_1 = '0;
        fwd_data_2 = '0;
    end
`endif

endmodule
